uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8 (power of two, 4..64): number of receive FIFO entries.
REQ-002 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: single clock for all logic (40 MHz nominal).
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset; synchronous and active-high.
REQ-005 SHALL have port clk_div, input, DIV_W bits: clock cycles per bit (40000000/baud, so 4166 for 9600); legal minimum 4.
REQ-006 SHALL have port ser_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rd_en, input, 1 bit: pop the FIFO head.
REQ-008 SHALL have port rd_data, output, 8 bits: FIFO head, first-word-fall-through.
REQ-009 SHALL have port empty, output, 1 bit: FIFO holds no bytes.
REQ-010 SHALL have port full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: number of bytes stored.
REQ-012 SHALL have port rx_finish, output, 1 bit: one-cycle pulse for each byte pushed.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit reads 0.
REQ-014 SHALL have port overrun, output, 1 bit: sticky; a byte was lost because the FIFO was full.
REQ-015 SHALL have port err_clr, input, 1 bit: clears overrun.

Function
REQ-016 SHALL pass ser_rx through a 2-flop synchronizer; all following timing refers to the synchronized line, rx_s.
REQ-017 SHALL implement the states IDLE, START, DATA and STOP.
REQ-018 In IDLE, SHALL enter START on a 1->0 transition of rx_s, latch clk_div into a frame divisor and load the bit counter with div/2.
REQ-019 In START, when the counter expires, SHALL sample rx_s: if 1, treat it as a false start and return to IDLE with no output; if 0, go to DATA with the counter loaded with div.
REQ-020 In DATA, SHALL shift in one sample per div cycles into shift[7], shifting right, 8 bits LSB first; after bit 7, go to STOP.
REQ-021 In STOP, SHALL sample once after div cycles: if 1, push the byte; if 0, pulse frame_err and discard the byte. Either way, return to IDLE.
REQ-022 SHALL time the samples, for a falling edge at cycle T, as: start at T+div/2, data bit i at T+div/2+(i+1)*div, stop at T+div/2+9*div; the push is visible (count, rx_finish) one cycle later.
REQ-023 Changes to clk_div during a frame SHALL have no effect until the next frame.
REQ-024 SHALL require a 1->0 edge to re-arm after a frame error, so a held-low (break) line produces no repeated frames.
REQ-025 On a push while full with no pop, SHALL drop the byte, set overrun and not pulse rx_finish.
REQ-026 On a push and pop in the same cycle while full, SHALL accept both with no overrun; count is unchanged.
REQ-027 SHALL ignore rd_en while empty; on a push and pop in the same cycle while empty, SHALL accept the push only.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 On err_clr together with a new overrun event in the same cycle, the overrun event SHALL win and overrun stays 1.

Reset
REQ-030 With wb_rst_i=1 at a clock edge, SHALL force: state IDLE, pointers and count 0, empty=1, full=0, rx_finish=0, frame_err=0, overrun=0, synchronizer flops 1.
REQ-031 A reset mid-frame SHALL abandon the frame; after reset, reception re-arms only on a fresh falling edge.
REQ-032 rd_data SHALL be don't-care while empty.

Structure
REQ-033 SHALL take the state encodings, the 8N1 frame constants and the DEPTH default from a shared package uart_pkg.
REQ-034 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH and DEPTH), reusable by a future uart_tx_fifo.

Verification
REQ-035 With clk_div=16, receiving 0xA5 SHALL give rx_finish at T+8+144+1, count=1 and rd_data=0xA5; rd_en then gives empty=1.
REQ-036 A 3-cycle low glitch on ser_rx with clk_div=16 SHALL cause no rx_finish, no frame_err and count=0.
REQ-037 Receiving 0x3C with stop bit 0 SHALL give one frame_err pulse and count=0; a following valid 0x11 SHALL read back 0x11.
REQ-038 With DEPTH=8, sending 9 bytes 0x01..0x09 without reads SHALL give full=1, overrun=1, reads of 0x01..0x08, and overrun=0 after err_clr.
REQ-039 Popping in the same cycle as a push while full SHALL leave overrun=0 and count=8, with correct byte order.
REQ-040 Asserting wb_rst_i during data bit 4 SHALL leave count=0 and no pulses; the next full frame 0x5A SHALL be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 frame constants and
// default FIFO depth, for the receive path and a future transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int   DATA_BITS      = 8;
   localparam logic START_LEVEL    = 1'b0;
   localparam logic STOP_LEVEL     = 1'b1;
   localparam logic IDLE_LEVEL     = 1'b1;
   localparam int   FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head is held in a register
// that is refilled from the array (or bypassed from din) on every push/pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_next;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] dout_reg;
   logic             do_push;
   logic             do_pop;

   // A pop frees the slot a simultaneous push needs, so full+pop still accepts.
   always_comb begin
      do_pop      = pop && (count_reg != '0);
      do_push     = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);
      rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         dout_reg   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         rd_ptr_reg <= rd_ptr_next;
         if (do_push && !do_pop) begin
            count_reg <= count_reg + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - (AW+1)'(1);
         end
         // The new head is the incoming word when it lands on the head slot.
         if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= din;
         end else begin
            dout_reg <= mem[rd_ptr_next];
         end
      end
   end

   assign dout  = dout_reg;
   assign count = count_reg;
   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling and a receive FIFO, reporting
// frame errors and sticky overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int DIV_W = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [DIV_W-1:0]         clk_div,
   input  logic                     ser_rx,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     rx_finish,
   output logic                     frame_err,
   output logic                     overrun,
   input  logic                     err_clr
);

   localparam int BW = $clog2(DATA_BITS);

   logic                 sync1_reg;
   logic                 rx_s_reg;
   logic                 rx_prev_reg;
   rx_state_t            state_reg;
   logic [DIV_W-1:0]     div_reg;
   logic [DIV_W-1:0]     cnt_reg;
   logic [BW-1:0]        bit_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 push_reg;
   logic                 frame_err_reg;
   logic                 rx_finish_reg;
   logic                 overrun_reg;
   logic                 cnt_done;

   // Flops reset to the idle level so a reset never looks like a start edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_reg   <= IDLE_LEVEL;
         rx_s_reg    <= IDLE_LEVEL;
         rx_prev_reg <= IDLE_LEVEL;
      end else begin
         sync1_reg   <= ser_rx;
         rx_s_reg    <= sync1_reg;
         rx_prev_reg <= rx_s_reg;
      end
   end

   assign cnt_done = (cnt_reg <= DIV_W'(1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg     <= ST_IDLE;
         div_reg       <= '0;
         cnt_reg       <= '0;
         bit_reg       <= '0;
         shift_reg     <= '0;
         push_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         push_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // Edge-triggered so a held-low break line cannot re-arm.
               if ((rx_s_reg == START_LEVEL) && (rx_prev_reg == IDLE_LEVEL)) begin
                  div_reg   <= clk_div;
                  cnt_reg   <= clk_div >> 1;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_done) begin
                  if (rx_s_reg != START_LEVEL) begin
                     state_reg <= ST_IDLE;
                  end else begin
                     cnt_reg   <= div_reg;
                     bit_reg   <= '0;
                     state_reg <= ST_DATA;
                  end
               end else begin
                  cnt_reg <= cnt_reg - DIV_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt_done) begin
                  shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                  cnt_reg   <= div_reg;
                  if (bit_reg == BW'(DATA_BITS - 1)) begin
                     state_reg <= ST_STOP;
                  end else begin
                     bit_reg <= bit_reg + BW'(1);
                  end
               end else begin
                  cnt_reg <= cnt_reg - DIV_W'(1);
               end
            end
            ST_STOP: begin
               if (cnt_done) begin
                  if (rx_s_reg == STOP_LEVEL) begin
                     push_reg <= 1'b1;
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - DIV_W'(1);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Status flags follow the FIFO's own accept rule so they line up with count.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_finish_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         rx_finish_reg <= push_reg && (!full || rd_en);
         if (push_reg && full && !rd_en) begin
            overrun_reg <= 1'b1;
         end else if (err_clr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .srst  (wb_rst_i),
      .push  (push_reg),
      .pop   (rd_en),
      .din   (shift_reg),
      .dout  (rd_data),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign rx_finish = rx_finish_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [15:0] clk_div  = 16'd16;
   logic        ser_rx   = 1'b1;
   logic        rd_en    = 1'b0;
   logic        err_clr  = 1'b0;
   logic [7:0]  rd_data;
   logic        empty, full, rx_finish, frame_err, overrun;
   logic [3:0]  count;

   uart_rx_fifo #(.DEPTH(DEPTH), .DIV_W(16)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .clk_div   (clk_div),
      .ser_rx    (ser_rx),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .rx_finish (rx_finish),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fails_shown = 0;
   bit armed = 0;
   int fe_seen = 0;
   int rxf_seen = 0;

   typedef struct {
      int         s;
      logic [7:0] d;
      logic       good;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] mq[$];
   logic       m_rxf = 1'b0;
   logic       m_fe  = 1'b0;
   logic       m_ov  = 1'b0;
   logic       m_pop, m_ovset;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (fails_shown < 40) begin
            fails_shown++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
         end
      end
   endtask

   // Reference model: a byte queue plus predicted stop-sample cycles.
   always @(posedge wb_clk_i) begin
      cyc++;
      if (wb_rst_i) begin
         mq.delete();
         evq.delete();
         m_rxf = 1'b0;
         m_fe  = 1'b0;
         m_ov  = 1'b0;
         armed = 1'b1;
      end else begin
         m_rxf   = 1'b0;
         m_fe    = 1'b0;
         m_ovset = 1'b0;
         m_pop   = rd_en && (mq.size() > 0);
         if (m_pop) void'(mq.pop_front());
         foreach (evq[k]) begin
            if (evq[k].s == cyc && !evq[k].good) m_fe = 1'b1;
            if (evq[k].s + 1 == cyc && evq[k].good) begin
               if (mq.size() < DEPTH) begin
                  mq.push_back(evq[k].d);
                  m_rxf = 1'b1;
               end else begin
                  m_ovset = 1'b1;
               end
            end
         end
         while (evq.size() > 0 && evq[0].s + 1 <= cyc) void'(evq.pop_front());
         if (m_ovset) m_ov = 1'b1;
         else if (err_clr) m_ov = 1'b0;
      end
   end

   always @(negedge wb_clk_i) begin
      if (armed) begin
         check("count", count, mq.size());
         check("empty", empty, mq.size() == 0);
         check("full", full, mq.size() == DEPTH);
         check("rx_finish", rx_finish, m_rxf);
         check("frame_err", frame_err, m_fe);
         check("overrun", overrun, m_ov);
         if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
         if (frame_err === 1'b1) fe_seen++;
         if (rx_finish === 1'b1) rxf_seen++;
      end
   end

   task automatic wait_bits(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   // Called 1 time unit after a clock edge; nbits<8 aborts the frame early.
   task automatic send_frame(input logic [7:0] b, input logic stopb, input int nbits, input int div);
      ev_t e;
      if (nbits >= 8) begin
         e.s = cyc + 3 + div / 2 + 9 * div;
         e.d = b;
         e.good = stopb;
         evq.push_back(e);
      end
      ser_rx = 1'b0;
      wait_bits(div);
      for (int i = 0; i < 8; i++) begin
         if (i >= nbits) begin
            ser_rx = 1'b1;
            return;
         end
         ser_rx = b[i];
         wait_bits(div);
      end
      ser_rx = stopb;
      wait_bits(div);
      ser_rx = 1'b1;
      wait_bits(div);
   endtask

   task automatic read_check(input string name, input logic [7:0] exp);
      check(name, rd_data, exp);
      rd_en = 1'b1;
      wait_bits(1);
      rd_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int p0;

   initial begin
      wait_bits(3);
      wb_rst_i = 1'b0;
      check("reset_empty", empty, 1);
      check("reset_full", full, 0);
      check("reset_count", count, 0);
      check("reset_overrun", overrun, 0);
      wait_bits(5);

      // 0xA5 at div 16: rx_finish exactly T+8+144+1, T = 3 cycles after the line falls.
      p0 = cyc;
      fork
         send_frame(8'hA5, 1'b1, 8, 16);
         begin
            wait_cyc(p0 + 155);
            check("a5_early_finish", rx_finish, 0);
            wait_cyc(p0 + 156);
            check("a5_finish", rx_finish, 1);
            check("a5_count", count, 1);
            check("a5_data", rd_data, 8'hA5);
         end
      join
      read_check("a5_read", 8'hA5);
      check("a5_empty", empty, 1);

      // 3-cycle low glitch is a false start.
      rxf_seen = 0;
      fe_seen = 0;
      ser_rx = 1'b0;
      wait_bits(3);
      ser_rx = 1'b1;
      wait_bits(40);
      check("glitch_count", count, 0);
      check("glitch_finish", rxf_seen, 0);
      check("glitch_ferr", fe_seen, 0);

      // Bad stop bit, then a good frame.
      send_frame(8'h3C, 1'b0, 8, 16);
      check("ferr_pulses", fe_seen, 1);
      check("ferr_count", count, 0);
      send_frame(8'h11, 1'b1, 8, 16);
      check("after_ferr_count", count, 1);
      read_check("after_ferr_read", 8'h11);

      // Divisor changes mid-frame are ignored; then small divisors 4 and 5.
      fork
         send_frame(8'h96, 1'b1, 8, 16);
         begin
            wait_bits(30);
            clk_div = 16'd7;
            wait_bits(100);
            clk_div = 16'd16;
         end
      join
      read_check("divchg_read", 8'h96);
      clk_div = 16'd4;
      send_frame(8'hC3, 1'b1, 8, 4);
      clk_div = 16'd5;
      send_frame(8'h69, 1'b1, 8, 5);
      clk_div = 16'd16;
      read_check("div4_read", 8'hC3);
      read_check("div5_read", 8'h69);

      // Nine bytes into eight slots.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 8, 16);
      check("ovf_full", full, 1);
      check("ovf_overrun", overrun, 1);
      check("ovf_count", count, 8);
      err_clr = 1'b1;
      wait_bits(1);
      err_clr = 1'b0;
      check("ovf_clr", overrun, 0);
      for (int i = 1; i <= 8; i++) read_check("ovf_read", 8'(i));
      check("ovf_empty", empty, 1);

      // Push and pop together while full.
      for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 8, 16);
      p0 = cyc;
      fork
         send_frame(8'h28, 1'b1, 8, 16);
         begin
            wait_cyc(p0 + 3 + 8 + 144);
            rd_en = 1'b1;
            wait_bits(1);
            rd_en = 1'b0;
         end
      join
      check("fullpop_overrun", overrun, 0);
      check("fullpop_count", count, 8);
      for (int i = 1; i <= 8; i++) read_check("fullpop_read", 8'h20 + 8'(i));

      // Reset during data bit 4 abandons the frame.
      rxf_seen = 0;
      fe_seen = 0;
      send_frame(8'hA7, 1'b1, 4, 16);
      wait_bits(4);
      wb_rst_i = 1'b1;
      wait_bits(1);
      wb_rst_i = 1'b0;
      wait_bits(200);
      check("rst_mid_count", count, 0);
      check("rst_mid_finish", rxf_seen, 0);
      check("rst_mid_ferr", fe_seen, 0);
      send_frame(8'h5A, 1'b1, 8, 16);
      check("post_rst_count", count, 1);
      read_check("post_rst_read", 8'h5A);
      wait_bits(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
